// File: rtl/stage_id_q.sv
// RV32I decode stage feeding a DEPTH-entry queue of decoded ops, with valid/ready on both
// sides and a one-cycle load-use bubble ahead of the execute stage.
module stage_id_q #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned LOAD_USE    = 1,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned INST_ADDR_W = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned ALU_SRC_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [INST_ADDR_W-1:0] in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_is_load,
    output logic                   out_is_store,
    output logic                   out_reg_wr,
    output logic [REG_ADDR_W-1:0]  out_rd,
    output logic [REG_ADDR_W-1:0]  out_rs1,
    output logic [REG_ADDR_W-1:0]  out_rs2,
    output logic [3:0]             out_alu_op,
    output logic [ALU_SRC_W-1:0]   out_alu_src1,
    output logic [ALU_SRC_W-1:0]   out_alu_src2,
    output logic [DATA_W-1:0]      out_imm,
    output logic                   out_is_jump,
    output logic                   out_is_jal,
    output logic                   out_is_branch,
    output logic [2:0]             out_branch_type,
    output logic                   out_illegal,
    output logic [INST_ADDR_W-1:0] out_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [ALU_SRC_W-1:0] ALU_SRC_R   = ALU_SRC_W'(0);
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM = ALU_SRC_W'(1);
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_PC  = ALU_SRC_W'(2);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic                   is_load;
        logic                   is_store;
        logic                   reg_wr;
        logic [REG_ADDR_W-1:0]  rd;
        logic [REG_ADDR_W-1:0]  rs1;
        logic [REG_ADDR_W-1:0]  rs2;
        logic [3:0]             alu_op;
        logic [ALU_SRC_W-1:0]   src1;
        logic [ALU_SRC_W-1:0]   src2;
        logic [DATA_W-1:0]      imm;
        logic                   is_jump;
        logic                   is_jal;
        logic                   is_branch;
        logic [2:0]             br_type;
        logic                   illegal;
        logic [INST_ADDR_W-1:0] pc;
    } entry_t;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;

    entry_t dec_c;
    entry_t head_c;
    logic   push_c;
    logic   pop_c;
    logic   hazard_c;

    // Combinational RV32I decode of the incoming instruction
    always_comb begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        is_ld, is_st, is_br, is_jalr, is_jal, is_alui, is_alur, is_lui, is_auipc;
        logic        known, rev;
        logic [31:0] imm32;

        opc      = in_inst[6:0];
        f3       = in_inst[14:12];
        f7       = in_inst[31:25];
        is_ld    = (opc == OP_LOAD);
        is_st    = (opc == OP_STORE);
        is_br    = (opc == OP_BRANCH);
        is_jalr  = (opc == OP_JALR);
        is_jal   = (opc == OP_JAL);
        is_alui  = (opc == OP_ALUI);
        is_alur  = (opc == OP_ALUR);
        is_lui   = (opc == OP_LUI);
        is_auipc = (opc == OP_AUIPC);
        known    = is_ld | is_st | is_br | is_jalr | is_jal | is_alui | is_alur | is_lui | is_auipc;

        imm32 = 32'd0;
        if (is_ld || is_alui || is_jalr) begin
            imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            // shift-immediates carry only the shamt; func7 selects the shift kind
            if (is_alui && (f3 == 3'b001 || f3 == 3'b101)) begin
                imm32 = {27'd0, in_inst[24:20]};
            end
        end else if (is_st) begin
            imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end else if (is_br) begin
            imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        end else if (is_jal) begin
            imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        end else if (is_lui || is_auipc) begin
            imm32 = {in_inst[31:12], 12'd0};
        end

        rev = 1'b0;
        if (is_alur || (is_alui && f3 == 3'b101)) begin
            rev = in_inst[30];
        end

        dec_c           = '0;
        dec_c.illegal   = !known || (is_alur && f7 != 7'h00 && f7 != 7'h20);
        dec_c.is_load   = is_ld & !dec_c.illegal;
        dec_c.is_store  = is_st & !dec_c.illegal;
        dec_c.rd        = REG_ADDR_W'(in_inst[11:7]);
        dec_c.rs1       = (is_lui || is_jal || is_auipc) ? '0 : REG_ADDR_W'(in_inst[19:15]);
        dec_c.rs2       = (is_br || is_st || is_alur) ? REG_ADDR_W'(in_inst[24:20]) : '0;
        dec_c.reg_wr    = (is_ld | is_lui | is_auipc | is_alui | is_alur | is_jal | is_jalr)
                          & (in_inst[11:7] != 5'd0) & !dec_c.illegal;
        dec_c.alu_op    = (is_alur || is_alui) ? {rev, f3} : 4'd0;
        dec_c.src1      = (is_br || is_jal || is_auipc) ? ALU_SRC_PC : ALU_SRC_R;
        dec_c.src2      = is_alur ? ALU_SRC_R : ALU_SRC_IMM;
        dec_c.imm       = DATA_W'($signed(imm32));
        dec_c.is_jump   = is_jalr;
        dec_c.is_jal    = is_jal;
        dec_c.is_branch = is_br;
        dec_c.br_type   = f3;
        dec_c.pc        = in_pc;
    end

    // Head of queue, load-use hazard detection and handshakes
    always_comb begin
        head_c    = mem_q[rd_ptr_q];
        hazard_c  = (LOAD_USE != 0) && (state_q == ST_RUN) && (count_q != '0) &&
                    (ld_rd_q != '0) && (head_c.rs1 == ld_rd_q || head_c.rs2 == ld_rd_q);
        in_ready  = (count_q < CNT_W'(DEPTH));
        out_valid = (count_q != '0) && !hazard_c;
        push_c    = in_valid && in_ready && !flush;
        pop_c     = out_valid && out_ready;
    end

    // Queue pointers, storage and count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = dec_c;
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Load-use FSM: a hazard withholds the head for one cycle, then BUBBLE releases it
    always_comb begin
        state_d = state_q;
        ld_rd_d = '0;
        case (state_q)
            ST_RUN:    if (hazard_c) state_d = ST_BUBBLE;
            ST_BUBBLE: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
        if (pop_c && head_c.is_load && head_c.rd != '0) begin
            ld_rd_d = head_c.rd;
        end
        if (flush) begin
            state_d = ST_RUN;
            ld_rd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_RUN;
            ld_rd_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            ld_rd_q  <= ld_rd_d;
        end
    end

    // Head entry presented to execute; side-effect flags gated by out_valid
    always_comb begin
        out_is_load     = out_valid & head_c.is_load;
        out_is_store    = out_valid & head_c.is_store;
        out_reg_wr      = out_valid & head_c.reg_wr;
        out_rd          = head_c.rd;
        out_rs1         = head_c.rs1;
        out_rs2         = head_c.rs2;
        out_alu_op      = head_c.alu_op;
        out_alu_src1    = head_c.src1;
        out_alu_src2    = head_c.src2;
        out_imm         = head_c.imm;
        out_is_jump     = head_c.is_jump;
        out_is_jal      = head_c.is_jal;
        out_is_branch   = head_c.is_branch;
        out_branch_type = head_c.br_type;
        out_illegal     = head_c.illegal;
        out_pc          = head_c.pc;
    end

endmodule

// File: tb/tb_stage_id_q.sv
// Directed-vector bench for stage_id_q with hand-computed expectations (DEPTH=2, LOAD_USE=1).
module tb_stage_id_q;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_load, out_is_store, out_reg_wr;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_alu_src1, out_alu_src2;
    logic [31:0] out_imm;
    logic        out_is_jump, out_is_jal, out_is_branch;
    logic [2:0]  out_branch_type;
    logic        out_illegal;
    logic [31:0] out_pc;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] SRC_R   = 32'd0;
    localparam logic [31:0] SRC_IMM = 32'd1;
    localparam logic [31:0] SRC_PC  = 32'd2;

    stage_id_q dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_inst         (in_inst),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_is_load     (out_is_load),
        .out_is_store    (out_is_store),
        .out_reg_wr      (out_reg_wr),
        .out_rd          (out_rd),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_alu_op      (out_alu_op),
        .out_alu_src1    (out_alu_src1),
        .out_alu_src2    (out_alu_src2),
        .out_imm         (out_imm),
        .out_is_jump     (out_is_jump),
        .out_is_jal      (out_is_jal),
        .out_is_branch   (out_is_branch),
        .out_branch_type (out_branch_type),
        .out_illegal     (out_illegal),
        .out_pc          (out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_reg_wr", 32'(out_reg_wr), 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // addi x1,x0,5 with out_ready=1
        out_ready = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_reg_wr", 32'(out_reg_wr), 32'd1);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_alu_op", 32'(out_alu_op), 32'd0);
        chk("addi_src1", 32'(out_alu_src1), SRC_R);
        chk("addi_src2", 32'(out_alu_src2), SRC_IMM);
        chk("addi_pc", out_pc, 32'h100);
        cyc();
        chk("addi_drained", 32'(out_valid), 32'd0);

        // backpressure: three pushes into two entries
        out_ready = 1'b0;
        drive(1'b1, 32'h00100113, 32'h200);
        cyc();
        chk("bp_ready1", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h00200193, 32'h204);
        cyc();
        chk("bp_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h00300213, 32'h208);
        cyc();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_head_a", out_pc, 32'h200);
        out_ready = 1'b1;
        cyc();
        chk("bp_head_b", out_pc, 32'h204);
        chk("bp_rd_b", 32'(out_rd), 32'd3);
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        chk("bp_head_c", out_pc, 32'h208);
        chk("bp_rd_c", 32'(out_rd), 32'd4);
        chk("bp_valid_c", 32'(out_valid), 32'd1);
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // load-use: lw x5,0(x2) ; add x6,x5,x1
        drive(1'b1, 32'h00012283, 32'h300);
        cyc();
        chk("lu_lw_valid", 32'(out_valid), 32'd1);
        chk("lu_lw_is_load", 32'(out_is_load), 32'd1);
        chk("lu_lw_rs1", 32'(out_rs1), 32'd2);
        drive(1'b1, 32'h00128333, 32'h304);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_bubble_reg_wr", 32'(out_reg_wr), 32'd0);
        cyc();
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_pc", out_pc, 32'h304);
        chk("lu_add_rs1", 32'(out_rs1), 32'd5);
        chk("lu_add_rs2", 32'(out_rs2), 32'd1);
        chk("lu_add_src2", 32'(out_alu_src2), SRC_R);
        cyc();
        chk("lu_drained", 32'(out_valid), 32'd0);

        // lw x0,0(x2) ; add x6,x0,x1 -> no bubble
        drive(1'b1, 32'h00012003, 32'h310);
        cyc();
        chk("lu0_lw_reg_wr", 32'(out_reg_wr), 32'd0);
        drive(1'b1, 32'h00100333, 32'h314);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        chk("lu0_no_bubble", 32'(out_valid), 32'd1);
        chk("lu0_add_pc", out_pc, 32'h314);
        cyc();

        // flush with a full queue and a pending input
        out_ready = 1'b0;
        drive(1'b1, 32'h00100113, 32'h400);
        cyc();
        drive(1'b1, 32'h00200193, 32'h404);
        cyc();
        chk("fl_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h00700393, 32'h408);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        // flush drops an input that could otherwise have been accepted
        drive(1'b1, 32'h00100113, 32'h410);
        cyc();
        drive(1'b1, 32'h00700393, 32'h414);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        chk("fl2_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("fl2_never_seen", 32'(out_valid), 32'd0);

        // jal x1,+8 ; auipc x3,1 ; srai x4,x4,2
        drive(1'b1, 32'h008000EF, 32'h500);
        cyc();
        chk("jal_imm", out_imm, 32'd8);
        chk("jal_src1", 32'(out_alu_src1), SRC_PC);
        chk("jal_is_jal", 32'(out_is_jal), 32'd1);
        chk("jal_reg_wr", 32'(out_reg_wr), 32'd1);
        drive(1'b1, 32'h00001197, 32'h504);
        cyc();
        chk("auipc_imm", out_imm, 32'h1000);
        chk("auipc_src1", 32'(out_alu_src1), SRC_PC);
        chk("auipc_rd", 32'(out_rd), 32'd3);
        drive(1'b1, 32'h40225213, 32'h508);
        cyc();
        chk("srai_imm", out_imm, 32'd2);
        chk("srai_src1", 32'(out_alu_src1), SRC_R);
        chk("srai_alu_op", 32'(out_alu_op), 32'hD);
        chk("srai_rs2", 32'(out_rs2), 32'd0);

        // illegal opcode 0x7F and ALUR with func7=0x01
        drive(1'b1, 32'h0000027F, 32'h600);
        cyc();
        chk("ill_op_valid", 32'(out_valid), 32'd1);
        chk("ill_op_flag", 32'(out_illegal), 32'd1);
        chk("ill_op_reg_wr", 32'(out_reg_wr), 32'd0);
        drive(1'b1, 32'h02128333, 32'h604);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        chk("ill_f7_flag", 32'(out_illegal), 32'd1);
        chk("ill_f7_reg_wr", 32'(out_reg_wr), 32'd0);
        cyc();

        // asynchronous reset with entries queued
        out_ready = 1'b0;
        drive(1'b1, 32'h00100113, 32'h700);
        cyc();
        drive(1'b1, 32'h00200193, 32'h704);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        chk("rst2_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("rst2_stays_empty", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
